// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared types, default sizes and port-field helper for the
//               regfile_sb register bank.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int ADDR_W_DEF   = 3;
    localparam int NUM_RD_DEF   = 2;
    localparam int PORT_BUS_MAX = 256;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    // Pulls field idx (each width bits) out of a zero-extended packed port bus.
    function automatic logic [31:0] port_field(
        input logic [PORT_BUS_MAX-1:0] bus,
        input int                      idx,
        input int                      width
    );
        logic [31:0] w_mask;
        w_mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return 32'(bus >> (idx * width)) & w_mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : One busy bit per register with reserve-set, writeback-clear
//               and sweep-clear; asynchronously cleared on reset.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set_en_i,
    input  logic [ADDR_W-1:0]    set_addr_i,
    input  logic                 clr_en_i,
    input  logic [ADDR_W-1:0]    clr_addr_i,
    input  logic                 sweep_en_i,
    input  logic [ADDR_W-1:0]    sweep_addr_i,
    output logic [2**ADDR_W-1:0] busy_o
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (sweep_en_i) begin
            busy_d[sweep_addr_i] = 1'b0;
        end else begin
            if (clr_en_i) begin
                busy_d[clr_addr_i] = 1'b0;
            end
            // Set is applied last so a same-cycle reservation beats the writeback.
            if (set_en_i) begin
                busy_d[set_addr_i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Multi-port register file with write-through bypass, busy
//               scoreboard and clear sequencer. Define REGFILE_ZERO_R0_EN to
//               hard-wire register 0 to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = NUM_RD_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_req,
    output logic                     ready,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] C_LAST_PTR = ADDR_W'(DEPTH - 1);

`ifdef REGFILE_ZERO_R0_EN
    localparam logic C_ZERO_R0 = 1'b1;
`else
    localparam logic C_ZERO_R0 = 1'b0;
`endif

    clr_state_e              state_q;
    clr_state_e              state_d;
    logic [ADDR_W-1:0]       ptr_q;
    logic [ADDR_W-1:0]       ptr_d;
    logic [DATA_W-1:0]       mem_q [DEPTH];

    logic [DEPTH-1:0]        w_busy;
    logic                    w_sweep;
    logic                    w_wr_ok;
    logic                    w_rsv_ok;
    logic [PORT_BUS_MAX-1:0] w_rd_addr_bus;

    assign ready    = (state_q == ST_IDLE);
    assign w_sweep  = (state_q == ST_CLEAR);
    assign w_wr_ok  = wr_en  & ready & ~(C_ZERO_R0 & (wr_addr  == '0));
    assign w_rsv_ok = rsv_en & ready & ~(C_ZERO_R0 & (rsv_addr == '0));

    assign w_rd_addr_bus = PORT_BUS_MAX'(rd_addr);

    // Clear sequencer: reset lands in CLEAR so storage is swept before first use.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            ST_CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == C_LAST_PTR) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Storage carries no reset so it can map onto RAM/LUT-RAM.
    always_ff @(posedge clk) begin
        if (w_sweep) begin
            mem_q[ptr_q] <= '0;
        end else if (w_wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .set_en_i     (w_rsv_ok),
        .set_addr_i   (rsv_addr),
        .clr_en_i     (w_wr_ok),
        .clr_addr_i   (wr_addr),
        .sweep_en_i   (w_sweep),
        .sweep_addr_i (ptr_q),
        .busy_o       (w_busy)
    );

    generate
        for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_port
            logic [ADDR_W-1:0] w_addr;
            logic              w_hit;
            logic              w_zero;

            assign w_addr = ADDR_W'(port_field(w_rd_addr_bus, i, ADDR_W));
            assign w_hit  = wr_en & (wr_addr == w_addr);
            assign w_zero = ~ready | (C_ZERO_R0 & (w_addr == '0));

            assign rd_data[i*DATA_W +: DATA_W] = w_zero ? '0 :
                                                 (w_hit ? wr_data : mem_q[w_addr]);
            assign rd_busy[i] = ~w_zero & w_busy[w_addr] & ~w_hit;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sb
// Description : Scoreboard bench for regfile_sb (default 8x8, two read ports).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int NR    = 2;
    localparam int DEPTH = 8;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b1;
    logic             clr_req  = 1'b0;
    logic             wr_en    = 1'b0;
    logic [AW-1:0]    wr_addr  = '0;
    logic [DW-1:0]    wr_data  = '0;
    logic             rsv_en   = 1'b0;
    logic [AW-1:0]    rsv_addr = '0;
    logic [NR*AW-1:0] rd_addr  = '0;
    logic             ready;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .ready    (ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NR*DW-1:0] d;
        logic [NR-1:0]    b;
        logic             rdy;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   fails   = 0;

    logic [DW-1:0] m_mem  [DEPTH];
    logic          m_busy [DEPTH];
    logic          m_clearing = 1'b0;
    int            m_ptr      = 0;

    function automatic logic r0_zero(input logic [AW-1:0] a);
`ifdef REGFILE_ZERO_R0_EN
        return (a == '0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_wipe();
        for (int k = 0; k < DEPTH; k++) begin
            m_mem[k]  = '0;
            m_busy[k] = 1'b0;
        end
        m_clearing = 1'b0;
        m_ptr      = 0;
        exp_q.delete();
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic re, input logic [AW-1:0] ra, input logic cr,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        rsv_en   = re;
        rsv_addr = ra;
        clr_req  = cr;
        rd_addr  = {a1, a0};
    endtask

    // Expected read-side view for the inputs currently driven.
    task automatic push_exp();
        exp_t          e;
        logic [AW-1:0] a;
        e.d   = '0;
        e.b   = '0;
        e.rdy = !m_clearing;
        for (int p = 0; p < NR; p++) begin
            a = rd_addr[p*AW +: AW];
            if (!m_clearing && !r0_zero(a)) begin
                if (wr_en && wr_addr == a) begin
                    e.d[p*DW +: DW] = wr_data;
                end else begin
                    e.d[p*DW +: DW] = m_mem[a];
                    e.b[p]          = m_busy[a];
                end
            end
        end
        exp_q.push_back(e);
    endtask

    // Advance the model by one clock edge, then the DUT.
    task automatic step();
        if (m_clearing) begin
            m_mem[m_ptr]  = '0;
            m_busy[m_ptr] = 1'b0;
            if (m_ptr == DEPTH - 1) begin
                m_clearing = 1'b0;
                m_ptr      = 0;
            end else begin
                m_ptr++;
            end
        end else begin
            if (wr_en && !r0_zero(wr_addr)) begin
                m_mem[wr_addr]  = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (rsv_en && !r0_zero(rsv_addr)) m_busy[rsv_addr] = 1'b1;
            if (clr_req) begin
                m_clearing = 1'b1;
                m_ptr      = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        int   n;
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", ready); end
        vectors++;
        if (rd_data !== '0) begin fails++; $display("FAIL reset_data: got %h want 0", rd_data); end
        vectors++;
        if (rd_busy !== '0) begin fails++; $display("FAIL reset_busy: got %b want 0", rd_busy); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        vectors++;
        if (n != DEPTH) begin fails++; $display("FAIL reset_sweep_len: got %0d want %0d", n, DEPTH); end
        model_wipe();
        for (int a = 0; a < DEPTH; a++) begin
            drive(0, 0, 0, 0, 0, 0, AW'(a), AW'(DEPTH - 1 - a));
            push_exp();
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (rd_data !== e.d) begin fails++; $display("FAIL reset_read a=%0d: got %h want %h", a, rd_data, e.d); end
            vectors++;
            if (rd_busy !== e.b) begin fails++; $display("FAIL reset_rdbusy a=%0d: got %b want %b", a, rd_busy, e.b); end
            step();
        end
    endtask

    task automatic test_write_read();
        exp_t e;
        drive(1, 3'd3, 8'hA5, 0, 0, 0, 3'd0, 3'd1);
        step();
        drive(0, 0, 0, 0, 0, 0, 3'd3, 3'd3);
        push_exp();
        @(negedge clk);
        e = exp_q.pop_front();
        for (int p = 0; p < NR; p++) begin
            vectors++;
            if (rd_data[p*DW +: DW] !== e.d[p*DW +: DW])
                begin fails++; $display("FAIL write_read port%0d: got %h want %h", p, rd_data[p*DW +: DW], e.d[p*DW +: DW]); end
        end
        step();
    endtask

    task automatic test_bypass();
        exp_t e;
        drive(0, 0, 0, 1, 3'd5, 0, 3'd3, 3'd5);
        step();
        drive(0, 0, 0, 0, 0, 0, 3'd3, 3'd5);
        push_exp();
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if (rd_busy !== e.b) begin fails++; $display("FAIL bypass_pre_busy: got %b want %b", rd_busy, e.b); end
        step();
        drive(1, 3'd5, 8'h3C, 0, 0, 0, 3'd3, 3'd5);
        push_exp();
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if (rd_data !== e.d) begin fails++; $display("FAIL bypass_data: got %h want %h", rd_data, e.d); end
        vectors++;
        if (rd_busy !== e.b) begin fails++; $display("FAIL bypass_busy: got %b want %b", rd_busy, e.b); end
        step();
    endtask

    task automatic test_scoreboard();
        exp_t e;
        // rsv, then writeback, then simultaneous rsv+wr on R2
        for (int s = 0; s < 3; s++) begin
            case (s)
                0:       drive(0, 0,     0,     1, 3'd2, 0, 3'd1, 3'd1);
                1:       drive(1, 3'd2, 8'h11, 0, 0,    0, 3'd1, 3'd1);
                default: drive(1, 3'd2, 8'h22, 1, 3'd2, 0, 3'd1, 3'd1);
            endcase
            step();
            drive(0, 0, 0, 0, 0, 0, 3'd2, 3'd2);
            push_exp();
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (rd_busy !== e.b) begin fails++; $display("FAIL sb_busy s=%0d: got %b want %b", s, rd_busy, e.b); end
            vectors++;
            if (rd_data !== e.d) begin fails++; $display("FAIL sb_data s=%0d: got %h want %h", s, rd_data, e.d); end
            step();
        end
        drive(1, 3'd2, 8'h22, 0, 0, 0, 0, 0);
        step();
    endtask

    task automatic test_clear();
        exp_t e;
        int   n;
        for (int a = 1; a < DEPTH; a++) begin
            drive(1, AW'(a), DW'(8'h10 + a), 1, AW'(a), 0, 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        step();
        for (int k = 0; k < DEPTH; k++) begin
            drive(1, AW'(k + DEPTH - 1), 8'hEE, 1, AW'(k + DEPTH - 1), 1, AW'(k), AW'(k + 1));
            push_exp();
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (ready !== e.rdy) begin fails++; $display("FAIL clr_ready k=%0d: got %b want %b", k, ready, e.rdy); end
            vectors++;
            if (rd_data !== e.d) begin fails++; $display("FAIL clr_data k=%0d: got %h want %h", k, rd_data, e.d); end
            step();
        end
        n = 0;
        for (int a = 0; a < DEPTH; a++) begin
            drive(0, 0, 0, 0, 0, 0, AW'(a), AW'(a));
            push_exp();
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (ready !== e.rdy) begin fails++; $display("FAIL post_clr_ready a=%0d: got %b want %b", a, ready, e.rdy); end
            vectors++;
            if (rd_data !== e.d || rd_busy !== e.b)
                begin fails++; $display("FAIL post_clr_read a=%0d: got %h/%b want %h/%b", a, rd_data, rd_busy, e.d, e.b); end
            step();
        end
    endtask

    task automatic test_zero_r0();
        exp_t e;
        drive(1, 3'd0, 8'hFF, 0, 0, 0, 3'd0, 3'd0);
        push_exp();
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if (rd_data !== e.d) begin fails++; $display("FAIL r0_bypass: got %h want %h", rd_data, e.d); end
        step();
        drive(0, 0, 0, 1, 3'd0, 0, 3'd0, 3'd4);
        push_exp();
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if (rd_data !== e.d) begin fails++; $display("FAIL r0_read: got %h want %h", rd_data, e.d); end
        step();
        drive(0, 0, 0, 0, 0, 0, 3'd4, 3'd0);
        push_exp();
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if (rd_busy !== e.b) begin fails++; $display("FAIL r0_busy: got %b want %b", rd_busy, e.b); end
        step();
        drive(1, 3'd0, 8'h00, 0, 0, 0, 0, 0);
        step();
    endtask

    task automatic test_reset_mid_sweep();
        exp_t e;
        int   n;
        drive(1, 3'd6, 8'h66, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (ready !== 1'b0 || rd_data !== '0)
            begin fails++; $display("FAIL midrst_outputs: got %b/%h want 0/0", ready, rd_data); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        vectors++;
        if (n != DEPTH) begin fails++; $display("FAIL midrst_sweep_len: got %0d want %0d", n, DEPTH); end
        model_wipe();
        drive(0, 0, 0, 0, 0, 0, 3'd6, 3'd2);
        push_exp();
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if (rd_data !== e.d || rd_busy !== e.b)
            begin fails++; $display("FAIL midrst_read: got %h/%b want %h/%b", rd_data, rd_busy, e.d, e.b); end
        step();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_clear();
        test_zero_r0();
        test_reset_mid_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire
